cla_sub_seq: RTL and testbench

//   Sequential borrow-lookahead subtractor: diff = a - b - bin over WIDTH bits.
//   One 4-bit lookahead slice is evaluated per clock, LSB slice first, and the

---
 rtl/cla_pkg.sv | 20 ++
 rtl/cla_sub_seq_if.sv | 38 +++
 rtl/cla_sub_slice4.sv | 36 +++
 rtl/cla_sub_seq.sv | 149 ++++++++++++++
 tb/tb_cla_sub_seq.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the sequential borrow-lookahead subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cla_pkg;

    // Bits evaluated per clock by the lookahead slice.
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_sub_state_t;

    // Number of slices needed to cover an operand of the given width.
    function automatic int nslices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_sub_seq_if.sv
// Operand/result handshake bundle for cla_sub_seq; ovf exists only with CLA_SUB_OVF_EN.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface cla_sub_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef CLA_SUB_OVF_EN
    logic             ovf;
`endif

    // Subtractor side.
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
`ifdef CLA_SUB_OVF_EN
        , output ovf
`endif
    );

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
`ifdef CLA_SUB_OVF_EN
        , input ovf
`endif
    );

endinterface

// File: rtl/cla_sub_slice4.sv
// Combinational 4-bit borrow-lookahead subtract slice with group propagate/generate.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller sequences it.
module cla_sub_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       br_in,
    output logic [3:0] d,
    output logic       br_out,
    output logic       grp_p,
    output logic       grp_g
);
    // Bit i generates a borrow when a_i=0, b_i=1; it passes an incoming
    // borrow through when a_i == b_i.
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] br;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Flattened lookahead: every internal borrow comes straight from br_in.
    assign br[0] = br_in;
    assign br[1] = g[0] | (p[0] & br_in);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_in);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & br_in);

    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;

    assign br_out = grp_g | (grp_p & br_in);
    assign d      = a ^ b ^ br;

endmodule

// File: rtl/cla_sub_seq.sv
// Sequential subtractor diff = a - b - bin, one 4-bit lookahead slice per clock, LSB first; optional ovf port with CLA_SUB_OVF_EN.
// Latency: out_valid rises WIDTH/4 cycles after the accept edge; one result per WIDTH/4+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module cla_sub_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    cla_sub_seq_if.slave    io
);
    localparam int NSL   = nslices(WIDTH);
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $fatal(1, "cla_sub_seq: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    cla_sub_state_t     state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic               br_q,    br_d;
    logic [WIDTH-1:0]   diff_q,  diff_d;
    logic               bout_q,  bout_d;
`ifdef CLA_SUB_OVF_EN
    logic               ovf_q,   ovf_d;
`endif

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_d;
    logic               sl_br_out;
    logic               sl_pg;
    logic               sl_gg;

    // Route the operand nibbles of the active slice to the shared lookahead unit.
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int k = 0; k < NSL; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sl_a = a_q[k*SLICE_W +: SLICE_W];
                sl_b = b_q[k*SLICE_W +: SLICE_W];
            end
        end
    end

    cla_sub_slice4 u_slice (
        .a      (sl_a),
        .b      (sl_b),
        .br_in  (br_q),
        .d      (sl_d),
        .br_out (sl_br_out),
        .grp_p  (sl_pg),
        .grp_g  (sl_gg)
    );

    // Next-state: accept operands in IDLE, walk the slices in RUN, hold the result in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef CLA_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.a;
                    b_d     = io.b;
                    br_d    = io.bin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < NSL; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        diff_d[k*SLICE_W +: SLICE_W] = sl_d;
                    end
                end
                // Inter-slice borrow taken from the group terms, as a tree would.
                br_d = sl_gg | (sl_pg & br_q);
                if (idx_q == IDX_W'(NSL - 1)) begin
                    bout_d  = sl_br_out;
`ifdef CLA_SUB_OVF_EN
                    // Overflow when operand signs differ and the result sign differs from a.
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sl_d[SLICE_W-1] ^ a_q[WIDTH-1]);
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef CLA_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef CLA_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.diff      = diff_q;
    assign io.bout      = bout_q;
`ifdef CLA_SUB_OVF_EN
    assign io.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_sub_seq.sv
// Bench for cla_sub_seq (WIDTH=16): directed vectors plus an arithmetic reference model.
// Latency: n/a.
// Backpressure: exercises result stalls and held in_valid.
module tb_cla_sub_seq;
    localparam int W   = 16;
    localparam int NSL = W / 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_sub_seq_if #(.WIDTH(W)) bus ();

    cla_sub_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int results = 0;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    exp_t expq[$];
    bit   front_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction, wrapped to W bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t e;
        int   d;
        d       = int'(a) - int'(b) - int'(bin);
        e.diff  = W'(d);
        e.bout  = (d < 0);
        e.ovf   = (a[W-1] ^ b[W-1]) & (e.diff[W-1] ^ a[W-1]);
        e.acc_cyc = 0;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Per-cycle compare of the DUT against the model queue.
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            front_seen = 1'b0;
        end else begin
            chk("rdy_vld_exclusive", 32'(bus.in_ready & bus.out_valid), 32'd0);
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got diff 0x%0h with no pending operation", bus.diff);
                end else begin
                    chk("model_diff", 32'(bus.diff), 32'(expq[0].diff));
                    chk("model_bout", 32'(bus.bout), 32'(expq[0].bout));
`ifdef CLA_SUB_OVF_EN
                    chk("model_ovf", 32'(bus.ovf), 32'(expq[0].ovf));
`endif
                    if (!front_seen) begin
                        chk("model_latency", 32'(cyc - expq[0].acc_cyc), 32'(NSL));
                        front_seen = 1'b1;
                    end
                    if (bus.out_ready) begin
                        void'(expq.pop_front());
                        front_seen = 1'b0;
                        results++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e = model(bus.a, bus.b, bus.bin);
                e.acc_cyc = cyc + 1;
                expq.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and hold in_valid until the accepting edge has passed.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int n;
        bit done;
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        n    = 0;
        done = 1'b0;
        while (!done && n < 30) begin
            if (bus.in_ready) done = 1'b1;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 within 30 cycles");
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        if (!bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: out_valid got 0 expected 1 within 30 cycles");
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] exp_d, input logic exp_bo,
                          input logic exp_ov);
        int n;
        accept(a, b, bin);
        wait_valid(n);
        chk({name, "_diff"}, 32'(bus.diff), 32'(exp_d));
        chk({name, "_bout"}, 32'(bus.bout), 32'(exp_bo));
`ifdef CLA_SUB_OVF_EN
        chk({name, "_ovf"}, 32'(bus.ovf), 32'(exp_ov));
`else
        if (exp_ov) begin end
`endif
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        #2;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_diff", 32'(bus.diff), 32'd0);
        chk("reset_bout", 32'(bus.bout), 32'd0);
`ifdef CLA_SUB_OVF_EN
        chk("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic with latency measured from the accept edge.
        accept(16'h1234, 16'h0034, 1'b0);
        wait_valid(n);
        chk("basic_latency", 32'(n), 32'd4);
        chk("basic_diff", 32'(bus.diff), 32'h1200);
        chk("basic_bout", 32'(bus.bout), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Underflow wrap-around.
        run_op("underflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("bin_equal", 16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Result stall with ignored in_valid pulses.
        accept(16'h1234, 16'h0034, 1'b0);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.a        = 16'hAAAA;
            bus.b        = 16'h1111;
            tick();
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_diff", 32'(bus.diff), 32'h1200);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("stall_release_valid", 32'(bus.out_valid), 32'd0);
        chk("stall_release_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back with in_valid held throughout.
        bus.out_ready = 1'b1;
        accept(16'h1234, 16'h0034, 1'b0);
        bus.a        = 16'h0000;
        bus.b        = 16'h0001;
        bus.bin      = 1'b0;
        bus.in_valid = 1'b1;
        wait_valid(n);
        chk("b2b_first_diff", 32'(bus.diff), 32'h1200);
        chk("b2b_busy_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("b2b_idle_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_second_run", 32'(bus.in_ready), 32'd0);
        wait_valid(n);
        chk("b2b_second_diff", 32'(bus.diff), 32'hFFFF);
        chk("b2b_second_bout", 32'(bus.bout), 32'd1);
        tick();
        bus.out_ready = 1'b0;

        // Reset while the third slice is being evaluated.
        accept(16'hAAAA, 16'h1111, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_diff", 32'(bus.diff), 32'd0);
        chk("midrst_bout", 32'(bus.bout), 32'd0);
`ifdef CLA_SUB_OVF_EN
        chk("midrst_ovf", 32'(bus.ovf), 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        run_op("after_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);

        // Signed overflow corners.
        run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        // Borrow-in at the extremes.
        run_op("max_bin", 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("zero_full", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);

        tick();
        tick();
        chk("queue_empty", 32'(expq.size()), 32'd0);
        chk("results_count", 32'(results), 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
